dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 44 ++++
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of two requester ports and the data-memory side.
// Ports (signals):
//   p0_req/p0_we/p0_addr/p0_wdata  -> arbiter   MEM-stage request
//   p0_ack/p0_rdata/p0_stall       <- arbiter   MEM-stage completion, load data, stall
//   p1_req/p1_we/p1_addr/p1_wdata  -> arbiter   loader/debug request
//   p1_ack/p1_rdata                <- arbiter   loader/debug completion, load data
//   mem_addr/mem_wdata/mem_read/mem_write <- arbiter, mem_rdata -> arbiter
// Modports: master = environment (requesters and memory), slave = arbiter.
interface dmem_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_ack;
    logic [31:0] p0_rdata;
    logic        p0_stall;
    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_ack;
    logic [31:0] p1_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_ack, p0_rdata, p0_stall, p1_ack, p1_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_ack, p0_rdata, p0_stall, p1_ack, p1_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single word-wide data memory.
// Ports: clk (rising edge), reset (async, active high),
//        bus (dmem_arbiter_if.slave): p0 = MEM stage, p1 = loader/debug, mem_* = DataMemory.
// Parameter MEM_LAT: memory access cycles (1..15).
// Macro DMEM_ARB_RR_EN: round-robin tie-break; default build uses fixed p0 priority.
module dmem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input logic      clk,
    input logic      reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        own;
    logic        l_we;
    logic [31:2] l_addr;
    logic [31:0] l_wdata;
    logic [31:0] p0_rd, p1_rd;
    logic        gnt1, take, done;

`ifdef DMEM_ARB_RR_EN
    logic last;
    // on a tie, p1 wins only if p0 was granted last
    assign gnt1 = bus.p1_req & (~bus.p0_req | ~last);
`else
    assign gnt1 = bus.p1_req & ~bus.p0_req;
`endif

    assign take = state == IDLE && (bus.p0_req || bus.p1_req);
    assign done = state == BUSY && cnt == 4'd1;

    assign bus.p0_rdata = p0_rd;
    assign bus.p1_rdata = p1_rd;
    assign bus.p0_stall = bus.p0_req & ~bus.p0_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            own     <= 1'b0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
            p0_rd   <= '0;
            p1_rd   <= '0;
`ifdef DMEM_ARB_RR_EN
            last    <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            if (take) begin
                own     <= gnt1;
                l_we    <= gnt1 ? bus.p1_we : bus.p0_we;
                l_addr  <= gnt1 ? bus.p1_addr[31:2] : bus.p0_addr[31:2];
                l_wdata <= gnt1 ? bus.p1_wdata : bus.p0_wdata;
                cnt     <= 4'(MEM_LAT);
`ifdef DMEM_ARB_RR_EN
                last    <= gnt1;
`endif
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            // load data is captured on the last access cycle, only for the owner
            if (done && !l_we && !own)
                p0_rd <= bus.mem_rdata;
            if (done && !l_we && own)
                p1_rd <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.p0_ack    = 1'b0;
        bus.p1_ack    = 1'b0;
        case (state)
            IDLE: state_nxt = take ? BUSY : IDLE;
            BUSY: begin
                bus.mem_addr  = {l_addr, 2'b00};
                bus.mem_wdata = l_wdata;
                bus.mem_write = l_we;
                bus.mem_read  = ~l_we;
                state_nxt     = done ? RESP : BUSY;
            end
            RESP: begin
                bus.p0_ack = ~own;
                bus.p1_ack = own;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench; bus a drives a MEM_LAT=1 arbiter, bus b a MEM_LAT=3 one.
// Inputs change on the falling edge, outputs are checked 1ns later.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    logic own_e;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    dmem_arbiter_if a ();
    dmem_arbiter_if b ();

    dmem_arbiter #(.MEM_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(a));
    dmem_arbiter #(.MEM_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        a.p0_req = 0; a.p0_we = 0; a.p0_addr = 0; a.p0_wdata = 0;
        a.p1_req = 0; a.p1_we = 0; a.p1_addr = 0; a.p1_wdata = 0; a.mem_rdata = 0;
        b.p0_req = 0; b.p0_we = 0; b.p0_addr = 0; b.p0_wdata = 0;
        b.p1_req = 0; b.p1_we = 0; b.p1_addr = 0; b.p1_wdata = 0; b.mem_rdata = 0;

        // reset state
        @(negedge clk); #1;
        chk("rst_p0_ack", a.p0_ack, 0);
        chk("rst_p1_ack", a.p1_ack, 0);
        chk("rst_p0_rdata", a.p0_rdata, 0);
        chk("rst_p1_rdata", b.p1_rdata, 0);
        chk("rst_read", a.mem_read, 0);
        chk("rst_write", b.mem_write, 0);
        chk("rst_addr", a.mem_addr, 0);
        chk("rst_wdata", b.mem_wdata, 0);
        a.p0_req = 1; #1;
        chk("rst_stall_req1", a.p0_stall, 1);
        a.p0_req = 0; #1;
        chk("rst_stall_req0", a.p0_stall, 0);
        @(negedge clk); reset = 1'b0;

        // MEM_LAT=1 load on p0
        @(negedge clk);
        a.p0_req = 1; a.p0_we = 0; a.p0_addr = 32'h10; a.mem_rdata = 32'hDEADBEEF; #1;
        chk("t1_idle_stall", a.p0_stall, 1);
        chk("t1_idle_read", a.mem_read, 0);
        @(negedge clk); #1;
        chk("t1_read", a.mem_read, 1);
        chk("t1_write", a.mem_write, 0);
        chk("t1_addr", a.mem_addr, 32'h10);
        chk("t1_busy_stall", a.p0_stall, 1);
        chk("t1_busy_ack", a.p0_ack, 0);
        @(negedge clk); #1;
        chk("t1_ack", a.p0_ack, 1);
        chk("t1_p1_ack", a.p1_ack, 0);
        chk("t1_rdata", a.p0_rdata, 32'hDEADBEEF);
        chk("t1_resp_stall", a.p0_stall, 0);
        chk("t1_resp_read", a.mem_read, 0);
        @(negedge clk); a.p0_req = 0; #1;
        chk("t1_ack_low", a.p0_ack, 0);
        chk("t1_p1_rdata", a.p1_rdata, 0);
        chk("t1_idle_read2", a.mem_read, 0);

        // MEM_LAT=3 store on p1, unaligned address
        @(negedge clk);
        b.p1_req = 1; b.p1_we = 1; b.p1_addr = 32'h23; b.p1_wdata = 32'h12345678;
        b.mem_rdata = 32'hCAFEF00D; #1;
        chk("t2_idle_write", b.mem_write, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("t2_write", b.mem_write, 1);
            chk("t2_read", b.mem_read, 0);
            chk("t2_addr", b.mem_addr, 32'h20);
            chk("t2_wdata", b.mem_wdata, 32'h12345678);
            chk("t2_busy_ack", b.p1_ack, 0);
        end
        @(negedge clk); #1;
        chk("t2_ack", b.p1_ack, 1);
        chk("t2_p0_ack", b.p0_ack, 0);
        chk("t2_resp_write", b.mem_write, 0);
        chk("t2_resp_addr", b.mem_addr, 0);
        chk("t2_rdata_kept", b.p1_rdata, 0);
        @(negedge clk); b.p1_req = 0; b.p1_we = 0; #1;
        chk("t2_ack_low", b.p1_ack, 0);

        // tie with both requests held, MEM_LAT=1
        @(negedge clk);
        a.p0_req = 1; a.p0_we = 0; a.p0_addr = 32'h40;
        a.p1_req = 1; a.p1_we = 0; a.p1_addr = 32'h80; #1;
        for (int k = 0; k < 3; k++) begin
            own_e = RR && k == 1;
            chk("t3_idle_stall", a.p0_stall, 1);
            @(negedge clk); a.mem_rdata = 32'hA0 + k; #1;
            chk("t3_addr", a.mem_addr, own_e ? 32'h80 : 32'h40);
            @(negedge clk); #1;
            chk("t3_p0_ack", a.p0_ack, !own_e);
            chk("t3_p1_ack", a.p1_ack, own_e);
            @(negedge clk); #1;
        end
        a.p0_req = 0; #1;
        chk("t3_p0_rdata", a.p0_rdata, 32'hA2);
        chk("t3_p1_rdata", a.p1_rdata, RR ? 32'hA1 : 32'h0);
        @(negedge clk); a.mem_rdata = 32'hB0; #1;
        chk("t3_p1_addr", a.mem_addr, 32'h80);
        @(negedge clk); #1;
        chk("t3_p1_last_ack", a.p1_ack, 1);
        chk("t3_p1_last_rdata", a.p1_rdata, 32'hB0);
        chk("t3_p0_rdata_kept", a.p0_rdata, 32'hA2);
        @(negedge clk); a.p1_req = 0; #1;
        chk("t3_ack_low", a.p1_ack, 0);

        // MEM_LAT=3 load, then reset in the second BUSY cycle of the next load
        @(negedge clk);
        b.p0_req = 1; b.p0_we = 0; b.p0_addr = 32'h44; b.mem_rdata = 32'h77; #1;
        repeat (4) @(negedge clk);
        #1;
        chk("t4_ack", b.p0_ack, 1);
        chk("t4_rdata", b.p0_rdata, 32'h77);
        @(negedge clk); b.p0_addr = 32'h48; b.mem_rdata = 32'h99; #1;
        @(negedge clk); #1;
        chk("t4_busy1_read", b.mem_read, 1);
        @(negedge clk); #1;
        chk("t4_busy2_read", b.mem_read, 1);
        chk("t4_busy2_addr", b.mem_addr, 32'h48);
        reset = 1'b1; #1;
        chk("t4_rst_read", b.mem_read, 0);
        chk("t4_rst_write", b.mem_write, 0);
        chk("t4_rst_addr", b.mem_addr, 0);
        chk("t4_rst_rdata", b.p0_rdata, 0);
        chk("t4_rst_ack", b.p0_ack, 0);
        chk("t4_rst_stall", b.p0_stall, 1);
        @(negedge clk); b.p0_req = 0; reset = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("t4_no_ack", b.p0_ack, 0);
            chk("t4_no_read", b.mem_read, 0);
        end

        // p0 drops its request mid-transaction, MEM_LAT=1
        @(negedge clk);
        a.p0_req = 1; a.p0_we = 0; a.p0_addr = 32'h8; a.mem_rdata = 32'h5A5A; #1;
        @(negedge clk); a.p0_req = 0; #1;
        chk("t5_read", a.mem_read, 1);
        chk("t5_stall", a.p0_stall, 0);
        @(negedge clk); #1;
        chk("t5_ack", a.p0_ack, 1);
        chk("t5_rdata", a.p0_rdata, 32'h5A5A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("t5_no_ack", a.p0_ack, 0);
            chk("t5_no_read", a.mem_read, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
